// File: rtl/ex_mc_pkg.sv
// ex_mc_pkg: op codes, operand-select codes, FSM states and flag bit indices shared by ex_stage_mc
package ex_mc_pkg;
   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_AND  = 2;
   localparam int OP_OR   = 3;
   localparam int OP_XOR  = 4;
   localparam int OP_SLT  = 5;
   localparam int OP_SLL  = 6;
   localparam int OP_SRL  = 7;
   localparam int OP_MUL  = 8;
   localparam int OP_DIVU = 9;
   localparam int OP_REMU = 10;
   localparam int OP_BEQ  = 11;
   localparam int OP_BNE  = 12;
   localparam int OP_JR   = 13;
   localparam logic [1:0] A_PC = 2'd0, A_PC1 = 2'd1, A_OPA = 2'd2, A_ZERO = 2'd3;
   localparam logic [1:0] B_IMM = 2'd0, B_OPB = 2'd1, B_IMM_SH = 2'd2, B_ZERO = 2'd3;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
   function automatic logic [2:0] mk_flag(input logic v, input logic n, input logic z);
      logic [2:0] f;
      f = '0;
      f[FLAG_V] = v;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction
endpackage

// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: decode-side and MEM-side handshake/bus of the execute stage
interface ex_stage_mc_if #(parameter int DATA_W = 32, parameter int OP_W = 4);
   logic              in_valid, in_ready, out_valid, out_ready, redirect, busy;
   logic [DATA_W-1:0] op_a, op_b, pc, imm, result, next_pc;
   logic [1:0]        a_sel, b_sel;
   logic [OP_W-1:0]   op;
   logic [2:0]        flag;
   modport slave (
      input  in_valid, op_a, op_b, pc, imm, a_sel, b_sel, op, out_ready,
      output in_ready, out_valid, result, flag, next_pc, redirect, busy
   );
   modport master (
      output in_valid, op_a, op_b, pc, imm, a_sel, b_sel, op, out_ready,
      input  in_ready, out_valid, result, flag, next_pc, redirect, busy
   );
endinterface

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider.
// EX_MUL_EARLY_EXIT_EN stops a multiply once the remaining multiplier is zero.
module ex_muldiv_iter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] prod_quo,
   output logic [DATA_W-1:0] remainder
);
   logic              run_q, run_d, div_q, div_d, ge, last, last_mul;
   logic [DATA_W-1:0] r_q, r_d, x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W:0]   shr, trial;
   // r: accumulator/partial remainder, x: multiplicand/quotient, y: multiplier/divisor
   always_comb begin
      shr = {r_q, x_q[DATA_W-1]};
      trial = shr - {1'b0, y_q};
      ge = !trial[DATA_W];
      last = cnt_q == CNT_W'(DATA_W - 1);
`ifdef EX_MUL_EARLY_EXIT_EN
      last_mul = last || y_q[DATA_W-1:1] == '0;
`else
      last_mul = last;
`endif
      done = run_q && (div_q ? last : last_mul);
      prod_quo = div_q ? x_q : r_q;
      remainder = r_q;
      run_d = run_q;
      div_d = div_q;
      r_d = r_q;
      x_d = x_q;
      y_d = y_q;
      cnt_d = cnt_q;
      if (start) begin
`ifdef EX_MUL_EARLY_EXIT_EN
         run_d = is_div || b != '0;
`else
         run_d = 1'b1;
`endif
         div_d = is_div;
         r_d = '0;
         x_d = a;
         y_d = b;
         cnt_d = '0;
      end else if (run_q) begin
         run_d = !done;
         cnt_d = cnt_q + CNT_W'(1);
         r_d = div_q ? (ge ? trial[DATA_W-1:0] : shr[DATA_W-1:0]) : (y_q[0] ? r_q + x_q : r_q);
         x_d = div_q ? {x_q[DATA_W-2:0], ge} : x_q << 1;
         y_d = div_q ? y_q : y_q >> 1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q <= 1'b0;
         div_q <= 1'b0;
         r_q <= '0;
         x_q <= '0;
         y_q <= '0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         div_q <= div_d;
         r_q <= r_d;
         x_q <= x_d;
         y_q <= y_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: multi-cycle execute stage (operand mux, ALU, branch resolve, iterative MUL/DIV).
// EX_MUL_EARLY_EXIT_EN lets a multiply finish early when its multiplier runs out of set bits.
module ex_stage_mc
   import ex_mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 6
) (
   input logic          clk,
   input logic          reset,
   ex_stage_mc_if.slave bus
);
   localparam int SH_W = $clog2(DATA_W);
   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_val, b_val, imm_sh, pc1, sum, diff, alu_res, md_q, md_r, md_res;
   logic [DATA_W-1:0] result_q, result_d, next_pc_q, next_pc_d, link_q, link_d;
   logic [OP_W-1:0]   mop_q, mop_d;
   logic [2:0]        flag_q, flag_d;
   logic [SH_W-1:0]   shamt;
   logic              out_valid_q, out_valid_d, redirect_q, redirect_d, busy_q, busy_d;
   logic              divz_q, divz_d, in_ready, accept, is_md, taken, ovf_alu, md_ovf;
   logic              md_done, mul_skip, load_alu, load_md;
   int                op_i;
   ex_muldiv_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_md (
      .clk(clk), .reset(reset), .start(accept && is_md), .is_div(op_i != OP_MUL),
      .a(a_val), .b(b_val), .done(md_done), .prod_quo(md_q), .remainder(md_r)
   );
   always_comb begin
      op_i = int'(bus.op);
      pc1 = bus.pc + DATA_W'(1);
      imm_sh = {{2{bus.imm[DATA_W-1]}}, bus.imm[DATA_W-1:2]};
      a_val = bus.a_sel == A_PC ? bus.pc : bus.a_sel == A_PC1 ? pc1 : bus.a_sel == A_OPA ? bus.op_a : '0;
      b_val = bus.b_sel == B_IMM ? bus.imm : bus.b_sel == B_OPB ? bus.op_b : bus.b_sel == B_IMM_SH ? imm_sh : '0;
      sum = a_val + b_val;
      diff = a_val - b_val;
      shamt = b_val[SH_W-1:0];
      taken = (op_i == OP_BEQ && a_val == b_val) || (op_i == OP_BNE && a_val != b_val);
      ovf_alu = op_i == OP_ADD ? (a_val[DATA_W-1] == b_val[DATA_W-1]) && (sum[DATA_W-1] != a_val[DATA_W-1]) :
                op_i == OP_SUB ? (a_val[DATA_W-1] != b_val[DATA_W-1]) && (diff[DATA_W-1] != a_val[DATA_W-1]) : 1'b0;
      alu_res = '0;
      case (op_i)
         OP_ADD:                 alu_res = sum;
         OP_SUB, OP_BEQ, OP_BNE: alu_res = diff;
         OP_AND:                 alu_res = a_val & b_val;
         OP_OR:                  alu_res = a_val | b_val;
         OP_XOR:                 alu_res = a_val ^ b_val;
         OP_SLT:                 alu_res = {{(DATA_W-1){1'b0}}, $signed(a_val) < $signed(b_val)};
         OP_SLL:                 alu_res = a_val << shamt;
         OP_SRL:                 alu_res = a_val >> shamt;
         OP_JR:                  alu_res = pc1;
         default:                alu_res = '0;
      endcase
      is_md = op_i == OP_MUL || op_i == OP_DIVU || op_i == OP_REMU;
      in_ready = state_q == IDLE && (!out_valid_q || bus.out_ready);
      accept = bus.in_valid && in_ready;
`ifdef EX_MUL_EARLY_EXIT_EN
      mul_skip = b_val == '0;
`else
      mul_skip = 1'b0;
`endif
      state_d = state_q == IDLE ? (accept && is_md ? (op_i == OP_MUL ? (mul_skip ? FIN : MUL) : DIV) : IDLE) :
                state_q == FIN ? IDLE : md_done ? FIN : state_q;
      // divide-by-zero is remembered from accept; the unit itself produces all-ones / dividend
      md_res = int'(mop_q) == OP_REMU ? md_r : md_q;
      md_ovf = int'(mop_q) != OP_MUL && divz_q;
      load_alu = accept && !is_md;
      load_md = state_q == FIN;
      out_valid_d = (load_alu || load_md) || (out_valid_q && !bus.out_ready);
      result_d = load_alu ? alu_res : load_md ? md_res : result_q;
      flag_d = load_alu ? mk_flag(ovf_alu, alu_res[DATA_W-1], alu_res == '0) :
               load_md ? mk_flag(md_ovf, md_res[DATA_W-1], md_res == '0) : flag_q;
      next_pc_d = load_alu ? (op_i == OP_JR ? bus.op_a : taken ? pc1 + bus.imm : pc1) :
                  load_md ? link_q : next_pc_q;
      redirect_d = load_alu ? (op_i == OP_JR || taken) : load_md ? 1'b0 : redirect_q;
      mop_d = accept ? bus.op : mop_q;
      link_d = accept ? pc1 : link_q;
      divz_d = accept ? b_val == '0 : divz_q;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         out_valid_q <= 1'b0;
         result_q <= '0;
         flag_q <= '0;
         next_pc_q <= '0;
         redirect_q <= 1'b0;
         busy_q <= 1'b0;
         mop_q <= '0;
         link_q <= '0;
         divz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_valid_q <= out_valid_d;
         result_q <= result_d;
         flag_q <= flag_d;
         next_pc_q <= next_pc_d;
         redirect_q <= redirect_d;
         busy_q <= busy_d;
         mop_q <= mop_d;
         link_q <= link_d;
         divz_q <= divz_d;
      end
   end
   assign bus.in_ready = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result = result_q;
   assign bus.flag = flag_q;
   assign bus.next_pc = next_pc_q;
   assign bus.redirect = redirect_q;
   assign bus.busy = busy_q;
endmodule
